// File: rtl/sensor_debounce_pkg.sv
// Shared constants for the home-alarm sensor front end: channel counts,
// default debounce length and the event_latched bit layout.
package home_alarm_pkg;
  localparam int unsigned N_OPENING           = 5;
  localparam int unsigned N_ALARM             = 4;
  localparam int unsigned N_CH                = N_OPENING + N_ALARM;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

  // event_latched / channel index layout: openings low, alarms high
  localparam int unsigned EV_OPEN_LO  = 0;
  localparam int unsigned EV_OPEN_HI  = N_OPENING - 1;
  localparam int unsigned EV_ALARM_LO = N_OPENING;
  localparam int unsigned EV_ALARM_HI = N_CH - 1;
endpackage

// File: rtl/sensor_debounce_if.sv
// Bundle of the sensor front-end signals; master drives raw lines and clear,
// slave is the debouncer side producing levels, pulses and latches.
interface sensor_debounce_if;
  import home_alarm_pkg::*;
  logic [N_OPENING-1:0] opening_raw;
  logic [N_ALARM-1:0]   alarm_raw;
  logic                 clear_latch;
  logic [N_OPENING-1:0] opening;
  logic [N_ALARM-1:0]   alarm;
  logic [N_OPENING-1:0] opening_rise;
  logic [N_ALARM-1:0]   alarm_rise;
  logic [N_CH-1:0]      event_latched;
  logic                 event_any;

  modport master (
    output opening_raw, alarm_raw, clear_latch,
    input  opening, alarm, opening_rise, alarm_rise, event_latched, event_any
  );
  modport slave (
    input  opening_raw, alarm_raw, clear_latch,
    output opening, alarm, opening_rise, alarm_rise, event_latched, event_any
  );
endinterface

// File: rtl/sensor_debounce_channel.sv
// Single-bit debouncer: 2-flop synchronizer, saturating mismatch counter,
// debounced level and a registered rise pulse.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while sync2 disagrees; the flip happens on the edge
  // that would otherwise take it past CNT_MAX, so it never wraps.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
endmodule

// File: rtl/sensor_debounce.sv
// Debounces door/window contacts and alarm sensors, emits rise pulses and
// keeps a sticky per-channel event record with a synchronous clear.
module sensor_debounce
  import home_alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_OPENING-1:0] opening_raw,
  input  logic [N_ALARM-1:0]   alarm_raw,
  input  logic                 clear_latch,
  output logic [N_OPENING-1:0] opening,
  output logic [N_ALARM-1:0]   alarm,
  output logic [N_OPENING-1:0] opening_rise,
  output logic [N_ALARM-1:0]   alarm_rise,
  output logic [N_CH-1:0]      event_latched,
  output logic                 event_any
);
  logic [N_CH-1:0] raw_all, level_all, rise_all;
  logic [N_CH-1:0] latch_q, latch_d;

  assign raw_all = {alarm_raw, opening_raw};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk     (clk),
      .rst_n   (reset),
      .raw_i   (raw_all[g]),
      .level_o (level_all[g]),
      .rise_o  (rise_all[g])
    );
  end

  // A rise coinciding with clear keeps its own bit; every other bit clears.
  always_comb begin
    latch_d = latch_q | rise_all;
    if (clear_latch) latch_d = rise_all;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) latch_q <= '0;
    else        latch_q <= latch_d;
  end

  assign opening       = level_all[EV_OPEN_HI:EV_OPEN_LO];
  assign alarm         = level_all[EV_ALARM_HI:EV_ALARM_LO];
  assign opening_rise  = rise_all[EV_OPEN_HI:EV_OPEN_LO];
  assign alarm_rise    = rise_all[EV_ALARM_HI:EV_ALARM_LO];
  assign event_latched = latch_q;
  assign event_any     = |latch_q;
endmodule

// File: tb/tb_sensor_debounce.sv
// Directed bench for sensor_debounce (DEBOUNCE_CYCLES=4): a window-based
// reference model checked every cycle plus hand-computed literal checks.
module tb_sensor_debounce;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  sensor_debounce_if bif();

  sensor_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk           (clk),
    .reset         (reset),
    .opening_raw   (bif.opening_raw),
    .alarm_raw     (bif.alarm_raw),
    .clear_latch   (bif.clear_latch),
    .opening       (bif.opening),
    .alarm         (bif.alarm),
    .opening_rise  (bif.opening_rise),
    .alarm_rise    (bif.alarm_rise),
    .event_latched (bif.event_latched),
    .event_any     (bif.event_any)
  );

  always #5 clk = ~clk;

  // Reference: a level flips once the last DC synchronized samples all
  // disagree with it; channel c is opening[c] for c<5, alarm[c-5] otherwise.
  logic [8:0]          m_s1, m_s2, m_stable, m_rise, m_lat;
  logic [8:0][DC-1:0]  m_hist;

  function automatic logic flips(logic [DC-1:0] h, logic s, logic st);
    logic [DC-1:0] w;
    w = {h[DC-2:0], s};
    return w == {DC{~st}};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 <= '0; m_s2 <= '0; m_stable <= '0; m_rise <= '0; m_lat <= '0;
      m_hist <= '0;
    end else begin
      for (int c = 0; c < 9; c++) begin
        m_hist[c]   <= {m_hist[c][DC-2:0], m_s2[c]};
        m_stable[c] <= flips(m_hist[c], m_s2[c], m_stable[c]) ? ~m_stable[c] : m_stable[c];
        m_rise[c]   <= flips(m_hist[c], m_s2[c], m_stable[c]) & ~m_stable[c];
      end
      m_lat <= bif.clear_latch ? m_rise : (m_lat | m_rise);
      m_s2  <= m_s1;
      m_s1  <= {bif.alarm_raw, bif.opening_raw};
    end
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      check("model_opening", 9'(bif.opening), 9'(m_stable[4:0]));
      check("model_alarm", 9'(bif.alarm), 9'(m_stable[8:5]));
      check("model_opening_rise", 9'(bif.opening_rise), 9'(m_rise[4:0]));
      check("model_alarm_rise", 9'(bif.alarm_rise), 9'(m_rise[8:5]));
      check("model_event_latched", bif.event_latched, m_lat);
      check("model_event_any", 9'(bif.event_any), 9'(|m_lat));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    bif.clear_latch = 1'b1;
    step();
    bif.clear_latch = 1'b0;
  endtask

  initial begin
    bif.opening_raw = 5'b11111;
    bif.alarm_raw   = 4'b0000;
    bif.clear_latch = 1'b0;
    step(2);
    en = 1'b1;
    check("rst_opening", 9'(bif.opening), 9'h000);
    check("rst_rise", 9'(bif.opening_rise), 9'h000);
    check("rst_latched", bif.event_latched, 9'h000);

    // Raw held high through release: edge 0 is the first post-release edge
    reset = 1'b1;
    step(5);
    check("rel_opening_e4", 9'(bif.opening), 9'h000);
    step();
    check("rel_opening_e5", 9'(bif.opening), 9'h01F);
    check("rel_rise_e5", 9'(bif.opening_rise), 9'h01F);
    step();
    check("rel_rise_e6", 9'(bif.opening_rise), 9'h000);
    check("rel_latched", bif.event_latched, 9'h01F);
    pulse_clear();
    check("clear_latched", bif.event_latched, 9'h000);

    // Held input: settle to 0, then raise only opening[2]
    bif.opening_raw = 5'b00000;
    step(8);
    check("drop_no_rise_lat", bif.event_latched, 9'h000);
    bif.opening_raw = 5'b00100;
    step(5);
    check("held_opening_e4", 9'(bif.opening), 9'h000);
    step();
    check("held_opening_e5", 9'(bif.opening), 9'h004);
    check("held_rise_e5", 9'(bif.opening_rise), 9'h004);
    step();
    check("held_rise_e6", 9'(bif.opening_rise), 9'h000);
    bif.opening_raw = 5'b00000;
    step(5);
    check("fall_opening_e4", 9'(bif.opening), 9'h004);
    step();
    check("fall_opening_e5", 9'(bif.opening), 9'h000);
    check("fall_no_rise", 9'(bif.opening_rise), 9'h000);
    step(2);
    pulse_clear();

    // Glitch of 3 cycles on alarm[2] must be rejected
    bif.alarm_raw = 4'b0100;
    step(3);
    bif.alarm_raw = 4'b0000;
    step(8);
    check("glitch_alarm", 9'(bif.alarm), 9'h000);
    check("glitch_any", 9'(bif.event_any), 9'h000);

    // Collision: clear lands in the alarm_rise[0] cycle, latch[1] already set
    bif.opening_raw = 5'b00010;
    step(7);
    check("coll_pre_latched", bif.event_latched, 9'h002);
    bif.alarm_raw = 4'b0001;
    step(6);
    check("coll_alarm_rise", 9'(bif.alarm_rise), 9'h001);
    pulse_clear();
    check("coll_latched", bif.event_latched, 9'h020);
    check("coll_any", 9'(bif.event_any), 9'h001);

    // Reset after two counting cycles on alarm[3]
    bif.alarm_raw = 4'b1001;
    step(4);
    reset = 1'b0;
    step();
    check("rmid_alarm_in_rst", 9'(bif.alarm), 9'h000);
    check("rmid_latched_in_rst", bif.event_latched, 9'h000);
    reset = 1'b1;
    step(5);
    check("rmid_alarm_e4", 9'(bif.alarm), 9'h000);
    step();
    check("rmid_alarm_e5", 9'(bif.alarm), 9'h009);
    check("rmid_opening_e5", 9'(bif.opening), 9'h002);

    // All nine channels change on the same edge
    bif.opening_raw = 5'b00000;
    bif.alarm_raw   = 4'b0000;
    step(8);
    pulse_clear();
    step();
    bif.opening_raw = 5'b11111;
    bif.alarm_raw   = 4'b1111;
    step(5);
    check("ind_levels_e4", {bif.alarm, bif.opening}, 9'h000);
    step();
    check("ind_levels_e5", {bif.alarm, bif.opening}, 9'h1FF);
    check("ind_rises_e5", {bif.alarm_rise, bif.opening_rise}, 9'h1FF);
    step();
    check("ind_rises_e6", {bif.alarm_rise, bif.opening_rise}, 9'h000);
    check("ind_latched", bif.event_latched, 9'h1FF);
    step(2);
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
